// File: rtl/if_prefetch.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue.
// Issues sequential word fetches, buffers {pc, inst, fault} entries and hands
// them to decode over valid/ready. A redirect flushes the queue and restarts
// fetch; a bus error queues a fault entry and halts fetching until redirected.
module if_prefetch #(
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_addr,
  output logic [1:0]  if_size,
  input  logic [63:0] if_data_read,
  input  logic [1:0]  if_resp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0]    SIZE_W  = 2'b10;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {
    MODE_FETCH,
    MODE_HALT
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [63:0]   q_pc_q    [DEPTH];
  logic [31:0]   q_inst_q  [DEPTH];
  logic          q_fault_q [DEPTH];

  logic          push, pop, push_fault;
  logic [31:0]   push_word;

  assign if_valid   = (mode_q == MODE_FETCH) && (count_q < FULL) && !redirect_valid;
  assign if_addr    = fetch_pc_q;
  assign if_size    = SIZE_W;
  assign push       = if_valid && if_ready;
  assign push_fault = (if_resp != 2'b00);
  assign push_word  = push_fault ? 32'h0 :
                      (fetch_pc_q[2] ? if_data_read[63:32] : if_data_read[31:0]);

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  assign out_pc     = out_valid ? q_pc_q[rd_ptr_q]    : '0;
  assign out_inst   = out_valid ? q_inst_q[rd_ptr_q]  : '0;
  assign out_fault  = out_valid ? q_fault_q[rd_ptr_q] : 1'b0;

  // Next-state: redirect overrides push/pop; push and pop together keep count.
  always_comb begin
    mode_d     = mode_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      mode_d     = MODE_FETCH;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 64'd4;
        if (push_fault) begin
          mode_d = MODE_HALT;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset empties the queue immediately via count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_FETCH;
      fetch_pc_q <= PC_START;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]    <= fetch_pc_q;
      q_inst_q[wr_ptr_q]  <= push_word;
      q_fault_q[wr_ptr_q] <= push_fault;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, full queue, redirect, bus error,
// pointer wrap at steady count, and asynchronous reset mid-cycle.
module tb_if_prefetch;

  localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic [63:0] if_data_read;
  logic [1:0]  if_resp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  logic        use_const;
  logic        err_en;
  logic [63:0] err_addr;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  if_prefetch #(.PC_START(PC0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_size(if_size), .if_data_read(if_data_read), .if_resp(if_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  // Distinct instruction word per word address.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Bus model: doubleword containing if_addr, optional error at err_addr.
  assign if_data_read = use_const ? 64'h1111_1111_0000_0013 :
                        {word_of({if_addr[63:3], 3'b100}), word_of({if_addr[63:3], 3'b000})};
  assign if_resp = (err_en && if_addr == err_addr) ? 2'b10 : 2'b00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b0; out_ready = 1'b0;
    err_en = 1'b0; use_const = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    out_ready = 1'b0; use_const = 1'b0; err_en = 1'b0; err_addr = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_if_valid", 64'(if_valid), 64'd1);
    check("rst_if_addr", if_addr, PC0);
    check("rst_if_size", 64'(if_size), 64'd2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    redirect_valid = 1'b1; #1;
    check("rst_redir_if_valid", 64'(if_valid), 64'd0);
    redirect_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Streaming with constant data
    use_const = 1'b1; if_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("stream_if_addr", if_addr, PC0 + 64'(4 * i));
      if (i == 0) begin
        check("stream_empty", 64'(out_valid), 64'd0);
      end else begin
        check("stream_out_valid", 64'(out_valid), 64'd1);
        check("stream_out_pc", out_pc, PC0 + 64'(4 * (i - 1)));
        check("stream_out_inst", 64'(out_inst),
              ((i - 1) % 2 == 0) ? 64'h13 : 64'h1111_1111);
      end
      @(negedge clk);
    end

    // Fill to DEPTH, stall, then drain in order with fetch resuming
    reset_dut();
    if_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_if_valid", 64'(if_valid), 64'd1);
      check("fill_if_addr", if_addr, PC0 + 64'(4 * i));
      @(negedge clk);
    end
    #1;
    check("full_if_valid", 64'(if_valid), 64'd0);
    check("full_if_addr", if_addr, 64'h8000_0010);
    check("full_out_pc", out_pc, PC0);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("resume_if_valid", 64'(if_valid), 64'd1);
    check("resume_if_addr", if_addr, 64'h8000_0010);
    for (int i = 1; i < 5; i++) begin
      check("drain_out_pc", out_pc, PC0 + 64'(4 * i));
      check("drain_out_inst", 64'(out_inst), 64'(word_of(PC0 + 64'(4 * i))));
      @(negedge clk); #1;
    end

    // Steady count=3 with simultaneous push/pop; pointers wrap
    reset_dut();
    if_ready = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("wrap_out_pc", out_pc, PC0 + 64'(4 * k));
      check("wrap_out_inst", 64'(out_inst), 64'(word_of(PC0 + 64'(4 * k))));
      check("wrap_if_addr", if_addr, 64'h8000_000C + 64'(4 * k));
      @(negedge clk);
    end
    if_ready = 1'b0;
    for (int k = 10; k < 13; k++) begin
      #1;
      check("wrap_tail_valid", 64'(out_valid), 64'd1);
      check("wrap_tail_pc", out_pc, PC0 + 64'(4 * k));
      @(negedge clk);
    end
    #1;
    check("wrap_tail_empty", 64'(out_valid), 64'd0);

    // Redirect with two entries queued
    reset_dut();
    if_ready = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1003; #1;
    check("redir_if_valid_n", 64'(if_valid), 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1; #1;
    check("redir_out_valid", 64'(out_valid), 64'd0);
    check("redir_if_valid", 64'(if_valid), 64'd1);
    check("redir_if_addr", if_addr, 64'h8000_1000);
    @(negedge clk); #1;
    check("redir_first_pc", out_pc, 64'h8000_1000);
    check("redir_first_inst", 64'(out_inst), 64'(word_of(64'h8000_1000)));
    @(negedge clk); #1;
    check("redir_second_pc", out_pc, 64'h8000_1004);

    // Bus error at 0x8000_0008
    reset_dut();
    err_en = 1'b1; err_addr = 64'h8000_0008;
    if_ready = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("err_if_valid", 64'(if_valid), 64'd0);
    check("err_if_addr", if_addr, 64'h8000_000C);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("err_pre_pc", out_pc, 64'h8000_0004);
    check("err_pre_fault", 64'(out_fault), 64'd0);
    @(negedge clk); #1;
    check("err_pc", out_pc, 64'h8000_0008);
    check("err_inst", 64'(out_inst), 64'd0);
    check("err_fault", 64'(out_fault), 64'd1);
    check("err_halt_valid", 64'(if_valid), 64'd0);
    @(negedge clk); #1;
    check("err_drained", 64'(out_valid), 64'd0);
    check("err_still_halt", 64'(if_valid), 64'd0);
    @(negedge clk);
    err_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    check("err_resume_valid", 64'(if_valid), 64'd1);
    check("err_resume_addr", if_addr, 64'h8000_0100);
    @(negedge clk); #1;
    check("err_resume_pc", out_pc, 64'h8000_0100);
    check("err_resume_fault", 64'(out_fault), 64'd0);

    // Asynchronous reset between edges
    reset_dut();
    if_ready = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    if_ready = 1'b0; #1;
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    #1; rst = 1'b1; #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_pc", out_pc, 64'd0);
    check("arst_if_addr", if_addr, PC0);
    check("arst_if_valid", 64'(if_valid), 64'd1);
    @(negedge clk); rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
